// File: rtl/hazard_pkg.sv
// Shared types and helpers for the register scoreboard.
package hazard_pkg;

    // Register-file geometry (integer and FP files are the same size)
    localparam int unsigned NREG = 32;
    localparam int unsigned RW   = $clog2(NREG);

    // Bit positions of the per-channel error event vector
    localparam int unsigned ERR_TIMEOUT  = 0;
    localparam int unsigned ERR_SPURIOUS = 1;
    localparam int unsigned ERR_W        = 2;

    typedef struct packed {
        logic          fp;
        logic [RW-1:0] idx;
    } reg_tag_t;

    // A source is pending if its bit is set in its file; integer x0 never is
    function automatic logic src_pending(input logic [NREG-1:0] pend_i,
                                         input logic [NREG-1:0] pend_f,
                                         input reg_tag_t        src);
        if (src.fp) begin
            return pend_f[src.idx];
        end
        return (src.idx != '0) && pend_i[src.idx];
    endfunction

endpackage

// File: rtl/hazard_channel.sv
// One multi-cycle execution channel: busy flag, destination tag, watchdog timer, start pulse.
module hazard_channel
    import hazard_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  reg_tag_t         tag_in,
    input  logic             wr_in,
    input  logic             done,
    output logic             busy,
    output logic             busy_nxt,
    output reg_tag_t         tag,
    output logic             wr,
    output logic             fu_start,
    output logic [ERR_W-1:0] err_ev
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT);
    // Event fires on the edge that makes the TIMEOUT-th busy cycle visible
    localparam logic [TW-1:0] TFIRE = TW'(TIMEOUT - 1);

    logic          busy_q, busy_d;
    reg_tag_t      tag_q, tag_d;
    logic          wr_q, wr_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          fu_start_q, fu_start_d;

    // Next-state: completion, saturating timer, then dispatch (dispatch overrides)
    always_comb begin
        busy_d     = busy_q;
        tag_d      = tag_q;
        wr_d       = wr_q;
        timer_d    = timer_q;
        fu_start_d = 1'b0;
        err_ev     = '0;
        if (done) begin
            if (busy_q) begin
                busy_d = 1'b0;
            end else begin
                err_ev[ERR_SPURIOUS] = 1'b1;
            end
        end else if (busy_q && (timer_q != TMAX)) begin
            timer_d = timer_q + TW'(1);
        end
        if (start) begin
            busy_d     = 1'b1;
            tag_d      = tag_in;
            wr_d       = wr_in;
            timer_d    = '0;
            fu_start_d = 1'b1;
        end
        err_ev[ERR_TIMEOUT] = busy_d && (timer_d >= TFIRE);
    end

    // Channel state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q     <= 1'b0;
            tag_q      <= '0;
            wr_q       <= 1'b0;
            timer_q    <= '0;
            fu_start_q <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            tag_q      <= tag_d;
            wr_q       <= wr_d;
            timer_q    <= timer_d;
            fu_start_q <= fu_start_d;
        end
    end

    assign busy     = busy_q;
    assign busy_nxt = busy_d;
    assign tag      = tag_q;
    assign wr       = wr_q;
    assign fu_start = fu_start_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-side register scoreboard over NUNIT multi-cycle channels.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned NUNIT       = 2,
    parameter int unsigned UW          = (NUNIT > 1) ? $clog2(NUNIT) : 1,
    parameter int unsigned TIMEOUT     = 255,
    parameter bit          DONE_BYPASS = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       valid_d,
    input  logic [RW-1:0]              rs1_d,
    input  logic [RW-1:0]              rs2_d,
    input  logic                       rs1_fp_d,
    input  logic                       rs2_fp_d,
    input  logic [RW-1:0]              rd_d,
    input  logic                       rd_fp_d,
    input  logic                       rd_we_d,
    input  logic                       mc_d,
    input  logic [UW-1:0]              unit_d,
    input  logic                       pc_src_e,
    input  logic                       cache_stall,
    input  logic [NUNIT-1:0]           fu_ready,
    input  logic [NUNIT-1:0]           fu_done,
    output logic                       stall_d,
    output logic [NUNIT-1:0]           fu_start,
    output logic [NUNIT-1:0]           busy,
    output logic [$clog2(NUNIT+1)-1:0] outstanding,
    output logic                       err_timeout,
    output logic                       err_spurious
);

    localparam int unsigned OW = $clog2(NUNIT + 1);

    logic [NREG-1:0]  pend_i_q, pend_i_d, pend_f_q, pend_f_d;
    logic [NREG-1:0]  clr_i, clr_f, set_i, set_f, eff_i, eff_f;
    logic [NUNIT-1:0] busy_eff, unit_sel, ch_wr, ch_busy_nxt;
    reg_tag_t         ch_tag [NUNIT];
    logic [ERR_W-1:0] ch_err [NUNIT];
    reg_tag_t         rs1_tag, rs2_tag, rd_tag;
    logic             raw, waw, hz_struct, accept, dispatch, rd_wr;
    logic [OW-1:0]    outstanding_q, outstanding_d;
    logic             err_timeout_q, err_timeout_d, err_spurious_q, err_spurious_d;

    assign rs1_tag = '{fp: rs1_fp_d, idx: rs1_d};
    assign rs2_tag = '{fp: rs2_fp_d, idx: rs2_d};
    assign rd_tag  = '{fp: rd_fp_d, idx: rd_d};
    assign rd_wr   = rd_we_d && (rd_fp_d || (rd_d != '0));

    // Pending bits released by this cycle's completions on busy channels
    always_comb begin
        clr_i = '0;
        clr_f = '0;
        for (int unsigned u = 0; u < NUNIT; u++) begin
            if (fu_done[u] && busy[u] && ch_wr[u]) begin
                if (ch_tag[u].fp) clr_f[ch_tag[u].idx] = 1'b1;
                else              clr_i[ch_tag[u].idx] = 1'b1;
            end
        end
    end

    // Hazard detection against the effective (optionally bypassed) pending state
    always_comb begin
        eff_i     = DONE_BYPASS ? (pend_i_q & ~clr_i) : pend_i_q;
        eff_f     = DONE_BYPASS ? (pend_f_q & ~clr_f) : pend_f_q;
        busy_eff  = DONE_BYPASS ? (busy & ~fu_done) : busy;
        unit_sel  = '0;
        for (int unsigned u = 0; u < NUNIT; u++) begin
            unit_sel[u] = (unit_d == UW'(u));
        end
        raw       = src_pending(eff_i, eff_f, rs1_tag) || src_pending(eff_i, eff_f, rs2_tag);
        waw       = rd_we_d && src_pending(eff_i, eff_f, rd_tag);
        // An out-of-range unit index has no channel and is held as a structural hazard
        hz_struct = mc_d && ((|(unit_sel & (busy_eff | ~fu_ready))) || (unit_sel == '0));
        stall_d   = cache_stall || (valid_d && !pc_src_e && (raw || waw || hz_struct));
        accept    = valid_d && !pc_src_e && !stall_d;
        dispatch  = accept && mc_d;
    end

    // Pending-vector update (a same-edge set beats a clear), sticky errors, busy count
    always_comb begin
        set_i = '0;
        set_f = '0;
        if (dispatch && rd_wr) begin
            if (rd_fp_d) set_f[rd_d] = 1'b1;
            else         set_i[rd_d] = 1'b1;
        end
        pend_i_d       = (pend_i_q & ~clr_i) | set_i;
        pend_f_d       = (pend_f_q & ~clr_f) | set_f;
        err_timeout_d  = err_timeout_q;
        err_spurious_d = err_spurious_q;
        outstanding_d  = '0;
        for (int unsigned u = 0; u < NUNIT; u++) begin
            err_timeout_d  = err_timeout_d  | ch_err[u][ERR_TIMEOUT];
            err_spurious_d = err_spurious_d | ch_err[u][ERR_SPURIOUS];
            outstanding_d  = outstanding_d + OW'(ch_busy_nxt[u]);
        end
    end

    // Scoreboard state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_i_q       <= '0;
            pend_f_q       <= '0;
            outstanding_q  <= '0;
            err_timeout_q  <= 1'b0;
            err_spurious_q <= 1'b0;
        end else begin
            pend_i_q       <= pend_i_d;
            pend_f_q       <= pend_f_d;
            outstanding_q  <= outstanding_d;
            err_timeout_q  <= err_timeout_d;
            err_spurious_q <= err_spurious_d;
        end
    end

    for (genvar u = 0; u < NUNIT; u++) begin : g_ch
        hazard_channel #(.TIMEOUT(TIMEOUT)) u_ch (
            .clk      (clk),
            .rst      (rst),
            .start    (dispatch && unit_sel[u]),
            .tag_in   (rd_tag),
            .wr_in    (rd_wr),
            .done     (fu_done[u]),
            .busy     (busy[u]),
            .busy_nxt (ch_busy_nxt[u]),
            .tag      (ch_tag[u]),
            .wr       (ch_wr[u]),
            .fu_start (fu_start[u]),
            .err_ev   (ch_err[u])
        );
    end

    assign outstanding  = outstanding_q;
    assign err_timeout  = err_timeout_q;
    assign err_spurious = err_spurious_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed table, corner sequences, random vs reference model.
module tb_hazard_scoreboard;

    localparam int NU = 2;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_d, rs1_fp_d, rs2_fp_d, rd_fp_d, rd_we_d, mc_d, pc_src_e, cache_stall;
    logic [4:0]  rs1_d, rs2_d, rd_d;
    logic [0:0]  unit_d;
    logic [1:0]  fu_ready, fu_done;
    logic        stall_d, err_timeout, err_spurious;
    logic [1:0]  fu_start, busy, outstanding;

    int checks = 0;
    int failures = 0;

    hazard_scoreboard #(.NUNIT(NU), .TIMEOUT(TO), .DONE_BYPASS(1'b1)) dut (
        .clk(clk), .rst(rst), .valid_d(valid_d), .rs1_d(rs1_d), .rs2_d(rs2_d),
        .rs1_fp_d(rs1_fp_d), .rs2_fp_d(rs2_fp_d), .rd_d(rd_d), .rd_fp_d(rd_fp_d),
        .rd_we_d(rd_we_d), .mc_d(mc_d), .unit_d(unit_d), .pc_src_e(pc_src_e),
        .cache_stall(cache_stall), .fu_ready(fu_ready), .fu_done(fu_done),
        .stall_d(stall_d), .fu_start(fu_start), .busy(busy), .outstanding(outstanding),
        .err_timeout(err_timeout), .err_spurious(err_spurious)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running required finished");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit       m_pi [32];
    bit       m_pf [32];
    bit       m_busy [NU];
    bit       m_tfp [NU];
    int       m_tidx [NU];
    bit       m_twr [NU];
    int       m_age [NU];
    bit [1:0] m_start;
    bit       m_eto, m_esp;

    function automatic void m_reset();
        for (int i = 0; i < 32; i++) begin m_pi[i] = 0; m_pf[i] = 0; end
        for (int u = 0; u < NU; u++) begin
            m_busy[u] = 0; m_tfp[u] = 0; m_tidx[u] = 0; m_twr[u] = 0; m_age[u] = 0;
        end
        m_start = '0; m_eto = 0; m_esp = 0;
    endfunction

    // Register still pending after accounting for any op finishing this cycle
    function automatic bit m_pend(input int idx, input bit fp);
        bit p;
        if (!fp && idx == 0) return 1'b0;
        p = fp ? m_pf[idx] : m_pi[idx];
        for (int u = 0; u < NU; u++)
            if (fu_done[u] && m_busy[u] && m_twr[u] && m_tfp[u] == fp && m_tidx[u] == idx) p = 1'b0;
        return p;
    endfunction

    function automatic bit m_stall();
        bit raw, waw, st;
        int u;
        u   = int'(unit_d);
        raw = m_pend(int'(rs1_d), rs1_fp_d) || m_pend(int'(rs2_d), rs2_fp_d);
        waw = rd_we_d && m_pend(int'(rd_d), rd_fp_d);
        st  = mc_d && ((m_busy[u] && !fu_done[u]) || !fu_ready[u]);
        return cache_stall || (valid_d && !pc_src_e && (raw || waw || st));
    endfunction

    function automatic void m_advance();
        bit acc;
        int u;
        acc = valid_d && !pc_src_e && !m_stall();
        for (int k = 0; k < NU; k++) begin
            if (fu_done[k]) begin
                if (m_busy[k]) begin
                    if (m_twr[k]) begin
                        if (m_tfp[k]) m_pf[m_tidx[k]] = 0; else m_pi[m_tidx[k]] = 0;
                    end
                    m_busy[k] = 0;
                end else m_esp = 1;
            end else if (m_busy[k]) m_age[k]++;
        end
        m_start = '0;
        if (acc && mc_d) begin
            u = int'(unit_d);
            m_busy[u] = 1; m_tfp[u] = rd_fp_d; m_tidx[u] = int'(rd_d);
            m_twr[u] = rd_we_d && (rd_fp_d || rd_d != 0);
            m_age[u] = 1; m_start[u] = 1;
            if (m_twr[u]) begin
                if (rd_fp_d) m_pf[m_tidx[u]] = 1; else m_pi[m_tidx[u]] = 1;
            end
        end
        for (int k = 0; k < NU; k++) if (m_busy[k] && m_age[k] >= TO) m_eto = 1;
    endfunction

    task automatic m_check(input int c);
        int n;
        n = int'(m_busy[0]) + int'(m_busy[1]);
        chk($sformatf("rnd%0d stall_d", c), 32'(stall_d), 32'(m_stall()));
        chk($sformatf("rnd%0d busy", c), 32'(busy), 32'({m_busy[1], m_busy[0]}));
        chk($sformatf("rnd%0d fu_start", c), 32'(fu_start), 32'(m_start));
        chk($sformatf("rnd%0d outstanding", c), 32'(outstanding), 32'(n));
        chk($sformatf("rnd%0d err_timeout", c), 32'(err_timeout), 32'(m_eto));
        chk($sformatf("rnd%0d err_spurious", c), 32'(err_spurious), 32'(m_esp));
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic valid; logic [4:0] rs1; logic f1; logic [4:0] rs2; logic f2;
        logic [4:0] rd; logic fd; logic we; logic mc; logic un; logic pc; logic cs;
        logic [1:0] rdy; logic [1:0] dn;
        logic e_stall; logic [1:0] e_busy; logic [1:0] e_start; logic [1:0] e_out; logic e_to;
    } vec_t;

    function automatic vec_t v(input int va, r1, f1, r2, f2, rd, fd, we, mc, un, pc, cs,
                               rdy, dn, es, eb, est, eo, eto);
        vec_t r;
        r.valid = 1'(va); r.rs1 = 5'(r1); r.f1 = 1'(f1); r.rs2 = 5'(r2); r.f2 = 1'(f2);
        r.rd = 5'(rd); r.fd = 1'(fd); r.we = 1'(we); r.mc = 1'(mc); r.un = 1'(un);
        r.pc = 1'(pc); r.cs = 1'(cs); r.rdy = 2'(rdy); r.dn = 2'(dn);
        r.e_stall = 1'(es); r.e_busy = 2'(eb); r.e_start = 2'(est); r.e_out = 2'(eo); r.e_to = 1'(eto);
        return r;
    endfunction

    task automatic idle_inputs();
        valid_d = 0; rs1_d = 0; rs1_fp_d = 0; rs2_d = 0; rs2_fp_d = 0; rd_d = 0; rd_fp_d = 0;
        rd_we_d = 0; mc_d = 0; unit_d = 0; pc_src_e = 0; cache_stall = 0; fu_ready = 2'b11; fu_done = 0;
    endtask

    task automatic drive(input vec_t r);
        valid_d = r.valid; rs1_d = r.rs1; rs1_fp_d = r.f1; rs2_d = r.rs2; rs2_fp_d = r.f2;
        rd_d = r.rd; rd_fp_d = r.fd; rd_we_d = r.we; mc_d = r.mc; unit_d = r.un;
        pc_src_e = r.pc; cache_stall = r.cs; fu_ready = r.rdy; fu_done = r.dn;
    endtask

    task automatic reset_dut(input string tag);
        idle_inputs();
        rst = 1;
        @(negedge clk);
        chk({tag, " rst stall_d"}, 32'(stall_d), 0);
        chk({tag, " rst busy"}, 32'(busy), 0);
        chk({tag, " rst fu_start"}, 32'(fu_start), 0);
        chk({tag, " rst outstanding"}, 32'(outstanding), 0);
        chk({tag, " rst errors"}, 32'({err_timeout, err_spurious}), 0);
        @(posedge clk); #1;
        rst = 0;
        m_reset();
    endtask

    vec_t tbl[$];

    initial begin
        //            va r1 f1 r2 f2 rd fd we mc un pc cs rdy dn   stall busy start out to
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0,  0, 0, 0, 0, 0)); // idle
        tbl.push_back(v(1, 1, 1, 2, 1, 3, 1, 1, 1, 0, 0, 0, 3, 0,  0, 0, 0, 0, 0)); // fadd f3 -> u0
        tbl.push_back(v(1, 3, 1, 1, 1, 4, 1, 1, 1, 1, 0, 0, 3, 0,  1, 1, 1, 1, 0)); // fmul reads f3
        tbl.push_back(v(1, 3, 1, 1, 1, 4, 1, 1, 1, 1, 0, 0, 3, 0,  1, 1, 0, 1, 0));
        tbl.push_back(v(1, 3, 1, 1, 1, 4, 1, 1, 1, 1, 0, 0, 3, 1,  0, 1, 0, 1, 0)); // done bypass
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0,  0, 2, 2, 1, 0)); // fu_start[1]
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 2,  0, 2, 0, 1, 0));
        tbl.push_back(v(1, 0, 0, 0, 0, 5, 1, 1, 1, 1, 0, 0, 3, 0,  0, 0, 0, 0, 0)); // mc f5 -> u1
        tbl.push_back(v(1, 2, 0, 3, 0, 1, 0, 1, 0, 0, 0, 0, 3, 0,  0, 2, 2, 1, 0)); // add x1,x2,x3
        tbl.push_back(v(1, 5, 1, 1, 1, 8, 1, 1, 0, 0, 0, 0, 3, 0,  1, 2, 0, 1, 0)); // reads f5
        tbl.push_back(v(1, 0, 0, 0, 0, 6, 1, 1, 1, 0, 0, 0, 3, 0,  0, 2, 0, 1, 0)); // mc f6 -> u0
        tbl.push_back(v(1, 0, 0, 0, 0, 7, 1, 1, 1, 0, 0, 0, 3, 0,  1, 3, 1, 2, 1)); // struct
        tbl.push_back(v(1, 0, 0, 0, 0, 7, 1, 1, 1, 0, 0, 0, 3, 0,  1, 3, 0, 2, 1));
        tbl.push_back(v(1, 0, 0, 0, 0, 7, 1, 1, 1, 0, 0, 0, 3, 1,  0, 3, 0, 2, 1)); // freed by done
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0,  0, 3, 1, 2, 1));
        tbl.push_back(v(1, 0, 0, 0, 0,10, 1, 1, 1, 0, 1, 0, 3, 0,  0, 3, 0, 2, 1)); // squashed
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 3,  1, 3, 0, 2, 1)); // cache stall
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0,  0, 0, 0, 0, 1));
        tbl.push_back(v(1, 7, 1, 0, 0,11, 1, 1, 0, 0, 0, 0, 3, 0,  0, 0, 0, 0, 1)); // f7 released
        tbl.push_back(v(1, 0, 0, 0, 0,12, 1, 1, 1, 1, 0, 0, 1, 0,  1, 0, 0, 0, 1)); // u1 not ready
        tbl.push_back(v(1, 0, 0, 0, 0,12, 1, 1, 1, 1, 0, 0, 3, 0,  0, 0, 0, 0, 1));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 3, 0,  0, 2, 2, 1, 1)); // mc writes x0
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 3, 0,  0, 3, 1, 2, 1)); // x0 never pending

        reset_dut("table");
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            @(negedge clk);
            chk($sformatf("row%0d stall_d", i), 32'(stall_d), 32'(tbl[i].e_stall));
            chk($sformatf("row%0d busy", i), 32'(busy), 32'(tbl[i].e_busy));
            chk($sformatf("row%0d fu_start", i), 32'(fu_start), 32'(tbl[i].e_start));
            chk($sformatf("row%0d outstanding", i), 32'(outstanding), 32'(tbl[i].e_out));
            chk($sformatf("row%0d err_timeout", i), 32'(err_timeout), 32'(tbl[i].e_to));
            @(posedge clk); #1;
        end

        // Watchdog: flag visible in the TIMEOUT-th busy cycle, sticky past completion
        reset_dut("timeout");
        valid_d = 1; mc_d = 1; unit_d = 0; rd_d = 9; rd_fp_d = 1; rd_we_d = 1;
        @(negedge clk);
        chk("timeout dispatch stall_d", 32'(stall_d), 0);
        @(posedge clk); #1;
        idle_inputs();
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk($sformatf("timeout busy cycle%0d busy", k), 32'(busy), 1);
            chk($sformatf("timeout busy cycle%0d err_timeout", k), 32'(err_timeout), 32'(k >= TO));
            @(posedge clk); #1;
        end
        fu_done = 2'b01;
        @(posedge clk); #1;
        fu_done = 2'b00;
        @(negedge clk);
        chk("timeout after done busy", 32'(busy), 0);
        chk("timeout after done err_timeout", 32'(err_timeout), 1);
        chk("timeout after done err_spurious", 32'(err_spurious), 0);
        @(posedge clk); #1;

        // Reset while busy, then a stale completion arrives
        reset_dut("rstbusy");
        valid_d = 1; mc_d = 1; unit_d = 0; rd_d = 9; rd_fp_d = 1; rd_we_d = 1;
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        chk("rstbusy busy before reset", 32'(busy), 1);
        #2 rst = 1;
        #1;
        chk("rstbusy in reset outputs", 32'({stall_d, fu_start, busy, outstanding, err_timeout, err_spurious}), 0);
        @(posedge clk); #1;
        rst = 0;
        fu_done = 2'b01;
        @(negedge clk);
        chk("rstbusy err_spurious before edge", 32'(err_spurious), 0);
        @(posedge clk); #1;
        fu_done = 2'b00;
        @(negedge clk);
        chk("rstbusy err_spurious", 32'(err_spurious), 1);
        chk("rstbusy busy", 32'(busy), 0);
        @(posedge clk); #1;
        valid_d = 1; rs1_d = 9; rs1_fp_d = 1; rd_d = 9; rd_fp_d = 1; rd_we_d = 1;
        @(negedge clk);
        chk("rstbusy f9 not pending", 32'(stall_d), 0);
        @(posedge clk); #1;

        // Random traffic against the reference model
        reset_dut("random");
        for (int c = 0; c < 1500; c++) begin
            valid_d     = ($urandom_range(0, 99) < 85);
            rs1_d       = 5'($urandom_range(0, 7));
            rs2_d       = 5'($urandom_range(0, 7));
            rd_d        = 5'($urandom_range(0, 7));
            rs1_fp_d    = 1'($urandom_range(0, 1));
            rs2_fp_d    = 1'($urandom_range(0, 1));
            rd_fp_d     = 1'($urandom_range(0, 1));
            rd_we_d     = ($urandom_range(0, 99) < 80);
            mc_d        = ($urandom_range(0, 99) < 40);
            unit_d      = 1'($urandom_range(0, 1));
            pc_src_e    = ($urandom_range(0, 15) == 0);
            cache_stall = ($urandom_range(0, 9) == 0);
            for (int u = 0; u < NU; u++) begin
                fu_ready[u] = ($urandom_range(0, 99) < 85);
                fu_done[u]  = m_busy[u] ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 99) == 0);
            end
            @(negedge clk);
            m_check(c);
            m_advance();
            @(posedge clk); #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
